pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-address controller for the PC register.
- Each cycle it decides whether the PC advances sequentially, holds, or is redirected to a branch target, jump target, interrupt vector or interrupt return address.
- Drives the PC's next-address and change-address inputs, and issues pipeline flush and interrupt acknowledge.
- Sits between decode/execute (redirect requesters) and the PC; it reads the PC's current address back.

Parameters:
- ADDR_W, 16, address width.
- INSTR_BYTES, 2, sequential increment per instruction.
- RESET_VECTOR, 16'h1040, first fetch address after reset.
- IRQ_VECTOR, 16'h0100, interrupt handler entry address.
- FLUSH_CYCLES, 2, cycles out_flush stays high after any redirect (range 1..7).

Ports:
- inp_clk  in  1  clock; all state updates on the rising edge.
- inp_reset  in  1  synchronous, active-high reset.
- inp_currentAddress  in  ADDR_W  PC register output (out_address of PC).
- inp_stall  in  1  fetch/hazard stall; hold the PC.
- inp_branchTaken  in  1  conditional branch resolved taken.
- inp_branchTarget  in  ADDR_W  branch destination.
- inp_jump  in  1  unconditional jump.
- inp_jumpTarget  in  ADDR_W  jump destination.
- inp_irq  in  1  level interrupt request.
- inp_reti  in  1  return-from-interrupt executed.
- out_nextInstructionAddress  out  ADDR_W  to PC inp_nextInstructionAddress.
- out_changeAddress  out  1  to PC inp_ChangeAddress; 1 = PC loads next address this edge, 0 = PC holds.
- out_flush  out  1  squash the fetched/decoded instructions.
- out_irqAck  out  1  one-cycle pulse when an interrupt is taken.
- out_epc  out  ADDR_W  saved return address.
- out_irqEnable  out  1  interrupts enabled.

Behaviour:
- Reset (synchronous, any state, mid-flush included):
  - state = S_BOOT, out_nextInstructionAddress = RESET_VECTOR, out_changeAddress = 0.
  - out_flush = 0, out_irqAck = 0, out_epc = 0, out_irqEnable = 1.
  - Pending-IRQ latch and flush counter cleared.
- Outputs are registered: a decision made in cycle N is visible in cycle N+1.
- State machine:
  - S_BOOT: drive RESET_VECTOR with changeAddress=1 for one cycle, then go to S_RUN.
  - S_RUN: evaluate requests.
  - S_FLUSH: count down FLUSH_CYCLES-1 further cycles, then return to S_RUN.
- S_RUN with inp_stall=1: changeAddress=0, all redirect requests ignored (requesters hold them until the stall clears); a pending IRQ stays pending.
- S_RUN without stall, priority pending-IRQ > reti > jump > branchTaken > sequential:
  - Sequential: next = currentAddress + INSTR_BYTES mod 2^ADDR_W, so 16'hFFFE wraps to 16'h0000. changeAddress=1, flush=0.
  - jump / branch: next = target with bit 0 forced to 0. changeAddress=1, flush=1, go to S_FLUSH.
  - IRQ (latch set and irqEnable=1): epc <= currentAddress, next = IRQ_VECTOR, irqAck=1 for one cycle, irqEnable <= 0, flush=1, go to S_FLUSH. A concurrent jump/branch is dropped; its instruction re-executes after reti.
  - reti: next = epc, irqEnable <= 1, flush=1, go to S_FLUSH.
- S_FLUSH:
  - flush=1 and the PC advances sequentially; stall still holds the PC.
  - Redirects are ignored because they come from squashed instructions.
  - inp_irq is still latched but not taken until S_RUN.
- IRQ latch:
  - Set when inp_irq=1 and irqEnable=1.
  - Cleared when the interrupt is taken.
  - inp_irq while irqEnable=0 is not latched.
- Nested interrupts are impossible (irqEnable=0 inside the handler); reti with irqEnable=1 behaves as a jump to epc.

Decomposition:
- pc_ctrl_pkg holds:
  - state encoding S_BOOT/S_RUN/S_FLUSH;
  - redirect-source encoding (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_IRQ, SRC_RETI);
  - default vector constants.
- One sub-module, pc_redirect_arbiter: combinational priority select producing the source code and target.
- The FSM, flush counter, IRQ latch and EPC remain in pc_sequencer.

Test Plan:
- Reset held 2 cycles, then released → cycle 1: next=16'h1040, change=1; following cycles 1042, 1044, 1046 with change=1.
- current=16'h1044, stall=1 for 3 cycles → change=0 for 3 cycles, next unchanged; stall released → next=16'h1046.
- current=16'h1046, branchTaken=1 and jump=1 simultaneously, branchTarget=16'h2000, jumpTarget=16'h3001 → next=16'h3000, flush=1 for 2 cycles, then next=16'h3002.
- irq=1 at current=16'h104A → next=16'h0100, irqAck pulse, epc=16'h104A, irqEnable=0; second irq ignored; reti → next=16'h104A, irqEnable=1.
- current=16'hFFFE, no requests → next=16'h0000; reset asserted during S_FLUSH → next=16'h1040, flush=0 next cycle.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared encodings and default vectors for the PC next-address controller
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_IRQ    = 3'd3,
    SRC_RETI   = 3'd4
  } src_t;

  localparam int unsigned DEF_ADDR_W       = 16;
  localparam int unsigned DEF_INSTR_BYTES  = 2;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h1040;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'h0100;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// rtl/pc_redirect_arbiter.sv - priority select of the next-address source and its target
module pc_redirect_arbiter
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              irq_take,
  input  logic              reti,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] irq_vector,
  output src_t              src,
  output logic [ADDR_W-1:0] target
);

  // Instructions are halfword aligned, so computed targets drop bit 0.
  always_comb begin
    src    = SRC_SEQ;
    target = seq_addr;
    if (irq_take) begin
      src    = SRC_IRQ;
      target = irq_vector;
    end else if (reti) begin
      src    = SRC_RETI;
      target = epc;
    end else if (jump) begin
      src    = SRC_JUMP;
      target = {jump_target[ADDR_W-1:1], 1'b0};
    end else if (branch_taken) begin
      src    = SRC_BRANCH;
      target = {branch_target[ADDR_W-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-address controller: boot, sequential, redirect, interrupt entry/return
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W       = DEF_ADDR_W,
  parameter int unsigned       INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
  parameter int unsigned       FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              inp_clk,
  input  logic              inp_reset,
  input  logic [ADDR_W-1:0] inp_currentAddress,
  input  logic              inp_stall,
  input  logic              inp_branchTaken,
  input  logic [ADDR_W-1:0] inp_branchTarget,
  input  logic              inp_jump,
  input  logic [ADDR_W-1:0] inp_jumpTarget,
  input  logic              inp_irq,
  input  logic              inp_reti,
  output logic [ADDR_W-1:0] out_nextInstructionAddress,
  output logic              out_changeAddress,
  output logic              out_flush,
  output logic              out_irqAck,
  output logic [ADDR_W-1:0] out_epc,
  output logic              out_irqEnable
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              change_q, change_d;
  logic              flush_q, flush_d;
  logic              ack_q, ack_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_pend_q, irq_pend_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] seq_addr;
  logic              irq_take;
  src_t              src;
  logic [ADDR_W-1:0] target;

  assign seq_addr = inp_currentAddress + ADDR_W'(INSTR_BYTES);
  assign irq_take = irq_pend_q & irq_en_q;

  pc_redirect_arbiter #(
    .ADDR_W(ADDR_W)
  ) u_arbiter (
    .irq_take      (irq_take),
    .reti          (inp_reti),
    .jump          (inp_jump),
    .branch_taken  (inp_branchTaken),
    .seq_addr      (seq_addr),
    .jump_target   (inp_jumpTarget),
    .branch_target (inp_branchTarget),
    .epc           (epc_q),
    .irq_vector    (IRQ_VECTOR),
    .src           (src),
    .target        (target)
  );

  always_ff @(posedge inp_clk) begin
    if (inp_reset) begin
      state_q    <= S_BOOT;
      next_q     <= RESET_VECTOR;
      epc_q      <= '0;
      change_q   <= 1'b0;
      flush_q    <= 1'b0;
      ack_q      <= 1'b0;
      irq_en_q   <= 1'b1;
      irq_pend_q <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      epc_q      <= epc_d;
      change_q   <= change_d;
      flush_q    <= flush_d;
      ack_q      <= ack_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    epc_d      = epc_q;
    change_d   = 1'b0;
    flush_d    = 1'b0;
    ack_d      = 1'b0;
    irq_en_d   = irq_en_q;
    cnt_d      = cnt_q;
    // The request level is captured even while stalled or flushing.
    irq_pend_d = irq_pend_q | (inp_irq & irq_en_q);

    unique case (state_q)
      S_BOOT: begin
        next_d   = RESET_VECTOR;
        change_d = 1'b1;
        state_d  = S_RUN;
      end

      S_RUN: begin
        if (!inp_stall) begin
          next_d   = target;
          change_d = 1'b1;
          if (src != SRC_SEQ) begin
            flush_d = 1'b1;
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_LOAD != 3'd0) ? S_FLUSH : S_RUN;
          end
          if (src == SRC_IRQ) begin
            epc_d      = inp_currentAddress;
            ack_d      = 1'b1;
            irq_en_d   = 1'b0;
            irq_pend_d = 1'b0;
          end
          if (src == SRC_RETI) begin
            irq_en_d = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        // Redirect requests here come from squashed instructions.
        flush_d = 1'b1;
        if (!inp_stall) begin
          next_d   = seq_addr;
          change_d = 1'b1;
        end
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign out_nextInstructionAddress = next_q;
  assign out_changeAddress          = change_q;
  assign out_flush                  = flush_q;
  assign out_irqAck                 = ack_q;
  assign out_epc                    = epc_q;
  assign out_irqEnable              = irq_en_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] current;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic        irq;
  logic        reti;
  logic [15:0] next_addr;
  logic        change;
  logic        flush;
  logic        irq_ack;
  logic [15:0] epc;
  logic        irq_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .inp_clk                    (clk),
    .inp_reset                  (reset),
    .inp_currentAddress         (current),
    .inp_stall                  (stall),
    .inp_branchTaken            (branch_taken),
    .inp_branchTarget           (branch_target),
    .inp_jump                   (jump),
    .inp_jumpTarget             (jump_target),
    .inp_irq                    (irq),
    .inp_reti                   (reti),
    .out_nextInstructionAddress (next_addr),
    .out_changeAddress          (change),
    .out_flush                  (flush),
    .out_irqAck                 (irq_ack),
    .out_epc                    (epc),
    .out_irqEnable              (irq_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input logic [15:0] exp_next, input logic exp_change,
                         input logic exp_flush);
    chk({tag, "_next"}, next_addr, exp_next);
    chk({tag, "_change"}, {15'd0, change}, {15'd0, exp_change});
    chk({tag, "_flush"}, {15'd0, flush}, {15'd0, exp_flush});
  endtask

  initial begin
    reset         = 1'b1;
    current       = 16'h0000;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    jump          = 1'b0;
    jump_target   = 16'h0000;
    irq           = 1'b0;
    reti          = 1'b0;

    tick();
    tick();
    chk_run("reset", 16'h1040, 1'b0, 1'b0);
    chk("reset_ack", {15'd0, irq_ack}, 16'd0);
    chk("reset_epc", epc, 16'h0000);
    chk("reset_irqen", {15'd0, irq_en}, 16'd1);

    reset = 1'b0;
    tick();
    chk_run("boot", 16'h1040, 1'b1, 1'b0);
    current = 16'h1040; tick(); chk_run("seq0", 16'h1042, 1'b1, 1'b0);
    current = 16'h1042; tick(); chk_run("seq1", 16'h1044, 1'b1, 1'b0);
    current = 16'h1044; tick(); chk_run("seq2", 16'h1046, 1'b1, 1'b0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_run("stall", 16'h1046, 1'b0, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk_run("unstall", 16'h1046, 1'b1, 1'b0);

    current       = 16'h1046;
    branch_taken  = 1'b1;
    branch_target = 16'h2000;
    jump          = 1'b1;
    jump_target   = 16'h3001;
    tick();
    chk_run("jump", 16'h3000, 1'b1, 1'b1);
    branch_taken = 1'b0;
    current      = 16'h3000;
    tick();
    chk_run("flush_ignore_jump", 16'h3002, 1'b1, 1'b1);
    jump    = 1'b0;
    current = 16'h3002;
    tick();
    chk_run("after_flush", 16'h3004, 1'b1, 1'b0);

    current = 16'h1048;
    irq     = 1'b1;
    tick();
    chk_run("irq_latch", 16'h104A, 1'b1, 1'b0);
    chk("irq_latch_ack", {15'd0, irq_ack}, 16'd0);
    current = 16'h104A;
    tick();
    chk_run("irq_take", 16'h0100, 1'b1, 1'b1);
    chk("irq_take_ack", {15'd0, irq_ack}, 16'd1);
    chk("irq_take_epc", epc, 16'h104A);
    chk("irq_take_en", {15'd0, irq_en}, 16'd0);
    current = 16'h0100;
    tick();
    chk_run("irq_flush", 16'h0102, 1'b1, 1'b1);
    chk("irq_ack_pulse", {15'd0, irq_ack}, 16'd0);
    current = 16'h0102;
    tick();
    chk_run("irq_second_ignored", 16'h0104, 1'b1, 1'b0);
    chk("irq_second_ack", {15'd0, irq_ack}, 16'd0);

    irq     = 1'b0;
    reti    = 1'b1;
    current = 16'h0104;
    tick();
    chk_run("reti", 16'h104A, 1'b1, 1'b1);
    chk("reti_en", {15'd0, irq_en}, 16'd1);
    reti    = 1'b0;
    current = 16'h104A;
    tick();
    chk_run("reti_flush", 16'h104C, 1'b1, 1'b1);
    current = 16'h104C;
    tick();
    chk_run("reti_done", 16'h104E, 1'b1, 1'b0);

    current = 16'hFFFE;
    tick();
    chk_run("wrap", 16'h0000, 1'b1, 1'b0);

    current     = 16'h0000;
    jump        = 1'b1;
    jump_target = 16'h4000;
    tick();
    chk_run("jump2", 16'h4000, 1'b1, 1'b1);
    jump  = 1'b0;
    reset = 1'b1;
    tick();
    chk_run("reset_in_flush", 16'h1040, 1'b0, 1'b0);
    chk("reset_in_flush_epc", epc, 16'h0000);
    chk("reset_in_flush_en", {15'd0, irq_en}, 16'd1);
    reset = 1'b0;
    tick();
    chk_run("reboot", 16'h1040, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
